// File: rtl/audio_codec_if.sv
// audio_codec_if: left-justified 16-bit master serial link (BCLK/LRCK gen, DAC serialiser, ADC capture)
module audio_codec_if #(
  parameter int BCLK_DIV = 4
) (
  input  logic        audio_clk,
  input  logic        reset,
  input  logic [15:0] audio_output,
  output logic [15:0] audio_input,
  output logic        sample_req,
  output logic        sample_end,
  output logic        aud_bclk,
  output logic        aud_daclrck,
  output logic        aud_adclrck,
  output logic        aud_dacdat,
  input  logic        aud_adcdat
);
  localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
  logic [DW-1:0] div_cnt;
  logic [4:0] bit_cnt, bit_nxt;
  logic [15:0] dac_hold, dac_shift;
  logic [14:0] adc_shift;
  logic tick, rise, fall, cap_d;
  assign tick = div_cnt == DW'(BCLK_DIV - 1);
  assign rise = tick & ~aud_bclk;
  assign fall = tick & aud_bclk;
  assign bit_nxt = bit_cnt + 5'd1;
  assign aud_adclrck = aud_daclrck;
  always_ff @(posedge audio_clk) begin
    if (reset) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      aud_bclk <= 1'b0;
      aud_daclrck <= 1'b0;
      aud_dacdat <= 1'b0;
      dac_hold <= '0;
      dac_shift <= '0;
      adc_shift <= '0;
      audio_input <= '0;
      sample_req <= 1'b0;
      sample_end <= 1'b0;
      cap_d <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) aud_bclk <= ~aud_bclk;
      sample_req <= fall && bit_nxt == 5'd31;
      cap_d <= rise && bit_cnt == 5'd15;
      sample_end <= cap_d;
      if (fall) begin
        bit_cnt <= bit_nxt;
        aud_daclrck <= bit_nxt[4];
        if (bit_nxt == 5'd0) begin
          dac_hold <= audio_output;
          aud_dacdat <= audio_output[15];
          dac_shift <= {audio_output[14:0], 1'b0};
        end else if (bit_nxt == 5'd16) begin
          aud_dacdat <= dac_hold[15];
          dac_shift <= {dac_hold[14:0], 1'b0};
        end else begin
          aud_dacdat <= dac_shift[15];
          dac_shift <= {dac_shift[14:0], 1'b0};
        end
      end
      // only the left slot is captured; right-channel bits never reach the shifter
      if (rise && !bit_cnt[4]) begin
        adc_shift <= {adc_shift[13:0], aud_adcdat};
        if (bit_cnt == 5'd15) audio_input <= {adc_shift, aud_adcdat};
      end
    end
  end
endmodule

// File: tb/tb_audio_codec_if.sv
// tb_audio_codec_if: checks BCLK_DIV=4 and BCLK_DIV=1 instances against a frame-arithmetic model
module tb_audio_codec_if;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] ao [2];
  logic [15:0] ai [2];
  logic req [2], send [2], bclk [2], dlr [2], alr [2], dd [2], ad [2];
  int dv [2] = '{4, 1};
  logic [15:0] dw [2][64], lw [2][64], rw [2][64];
  int checks = 0, errors = 0;
  bit fixed;
  typedef struct {
    int n;
    logic bclk, lr, req, send, dd;
    logic [15:0] ai;
  } vec_t;
  vec_t tbl [16];

  always #5 clk = ~clk;

  audio_codec_if #(.BCLK_DIV(4)) u4 (
    .audio_clk(clk), .reset(reset), .audio_output(ao[0]), .audio_input(ai[0]),
    .sample_req(req[0]), .sample_end(send[0]), .aud_bclk(bclk[0]), .aud_daclrck(dlr[0]),
    .aud_adclrck(alr[0]), .aud_dacdat(dd[0]), .aud_adcdat(ad[0]));

  audio_codec_if #(.BCLK_DIV(1)) u1 (
    .audio_clk(clk), .reset(reset), .audio_output(ao[1]), .audio_input(ai[1]),
    .sample_req(req[1]), .sample_end(send[1]), .aud_bclk(bclk[1]), .aud_daclrck(dlr[1]),
    .aud_adclrck(alr[1]), .aud_dacdat(dd[1]), .aud_adcdat(ad[1]));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input int tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d ai d%0d", tag, d), ai[d], 16'h0);
      chk($sformatf("rst%0d outs d%0d", tag, d),
          {11'b0, req[d], send[d], bclk[d], dlr[d], alr[d]}, 16'h0);
      chk($sformatf("rst%0d dacdat d%0d", tag, d), dd[d], 16'h0);
    end
  endtask

  // expected outputs after edge n, derived from frame/bit position arithmetic
  task automatic model_check(input int n);
    for (int d = 0; d < 2; d++) begin
      int dd_, p, f, b, fc;
      logic [15:0] w, eai;
      dd_ = dv[d];
      p = 64 * dd_;
      f = n / p;
      b = (n / (2 * dd_)) % 32;
      w = dw[d][f];
      eai = 16'h0;
      if (n >= 31 * dd_) begin
        fc = (n - 31 * dd_) / p;
        eai = lw[d][fc];
      end
      chk($sformatf("bclk d%0d n%0d", d, n), bclk[d], 16'((n / dd_) % 2));
      chk($sformatf("lrck d%0d n%0d", d, n), dlr[d], 16'(b >= 16));
      chk($sformatf("adclrck d%0d n%0d", d, n), alr[d], 16'(b >= 16));
      chk($sformatf("req d%0d n%0d", d, n), req[d], 16'(n % p == 62 * dd_));
      chk($sformatf("send d%0d n%0d", d, n), send[d], 16'(n % p == 31 * dd_ + 1));
      chk($sformatf("dacdat d%0d n%0d", d, n), dd[d], 16'(w[15 - (b % 16)]));
      chk($sformatf("ain d%0d n%0d", d, n), ai[d], eai);
      chk($sformatf("excl d%0d n%0d", d, n), 16'(req[d] & send[d]), 16'h0);
    end
  endtask

  task automatic drive(input int n);
    for (int d = 0; d < 2; d++) begin
      int dd_, p, f, b;
      logic [15:0] w;
      dd_ = dv[d];
      p = 64 * dd_;
      f = n / p;
      b = (n / (2 * dd_)) % 32;
      if (n > 0 && n % p == 62 * dd_) begin
        dw[d][f + 1] = (fixed && f == 0) ? 16'hA5C3 : 16'($urandom);
        ao[d] = dw[d][f + 1];
      end
      w = b < 16 ? lw[d][f] : rw[d][f];
      ad[d] = w[15 - (b % 16)];
    end
  endtask

  task automatic run(input int len, input bit use_tbl);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) begin
        lw[d][i] = fixed ? 16'h8001 : 16'($urandom);
        rw[d][i] = fixed ? 16'hFFFF : 16'($urandom);
        dw[d][i] = 16'h0;
      end
      ao[d] = 16'($urandom);
    end
    drive(0);
    for (int n = 1; n <= len; n++) begin
      @(posedge clk);
      #1;
      model_check(n);
      if (use_tbl)
        for (int t = 0; t < 16; t++)
          if (tbl[t].n == n) begin
            chk($sformatf("tbl bclk n%0d", n), bclk[0], tbl[t].bclk);
            chk($sformatf("tbl lrck n%0d", n), dlr[0], tbl[t].lr);
            chk($sformatf("tbl req n%0d", n), req[0], tbl[t].req);
            chk($sformatf("tbl send n%0d", n), send[0], tbl[t].send);
            chk($sformatf("tbl dacdat n%0d", n), dd[0], tbl[t].dd);
            chk($sformatf("tbl ain n%0d", n), ai[0], tbl[t].ai);
          end
      drive(n);
    end
  endtask

  initial begin
    tbl[0]  = '{3,   0, 0, 0, 0, 0, 16'h0000};
    tbl[1]  = '{4,   1, 0, 0, 0, 0, 16'h0000};
    tbl[2]  = '{8,   0, 0, 0, 0, 0, 16'h0000};
    tbl[3]  = '{123, 0, 0, 0, 0, 0, 16'h0000};
    tbl[4]  = '{124, 1, 0, 0, 0, 0, 16'h8001};
    tbl[5]  = '{125, 1, 0, 0, 1, 0, 16'h8001};
    tbl[6]  = '{126, 1, 0, 0, 0, 0, 16'h8001};
    tbl[7]  = '{128, 0, 1, 0, 0, 0, 16'h8001};
    tbl[8]  = '{248, 0, 1, 1, 0, 0, 16'h8001};
    tbl[9]  = '{249, 0, 1, 0, 0, 0, 16'h8001};
    tbl[10] = '{252, 1, 1, 0, 0, 0, 16'h8001};
    tbl[11] = '{256, 0, 0, 0, 0, 1, 16'h8001};
    tbl[12] = '{264, 0, 0, 0, 0, 0, 16'h8001};
    tbl[13] = '{272, 0, 0, 0, 0, 1, 16'h8001};
    tbl[14] = '{384, 0, 1, 0, 0, 1, 16'h8001};
    tbl[15] = '{392, 0, 1, 0, 0, 0, 16'h8001};
    for (int d = 0; d < 2; d++) begin
      ao[d] = 16'h0;
      ad[d] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0);
    reset = 1'b0;
    fixed = 1'b1;
    run(768, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_zero(1);
    reset = 1'b0;
    fixed = 1'b0;
    run(99, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_zero(2);
    reset = 1'b0;
    run(600, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
